// File: rtl/fetch_prefetch_if.sv
// ============================================================================
// Module   : fetch_prefetch_if
// Purpose  : Bundles the fetch control, memory, and instruction-stream signals.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_prefetch_if #(
    parameter int ADDR_W = 16
) ();
    logic                fetch_start;
    logic [3:0]          opCode_in;
    logic [8:0]          offset_in;
    logic [ADDR_W-1:0]   reg_in;
    logic [2:0]          br_nzp;
    logic [2:0]          result_nzp;
    logic                redirect_valid;
    logic [15:0]         mem_data_in;
    logic                inst_ready;
    logic [ADDR_W-1:0]   addr_out;
    logic                mem_rd_out;
    logic                wea_out;
    logic [15:0]         inst_out;
    logic                inst_valid;
    logic [ADDR_W-1:0]   pc;

    modport master (
        input  fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
               redirect_valid, mem_data_in, inst_ready,
        output addr_out, mem_rd_out, wea_out, inst_out, inst_valid, pc
    );

    modport slave (
        output fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
               redirect_valid, mem_data_in, inst_ready,
        input  addr_out, mem_rd_out, wea_out, inst_out, inst_valid, pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_prefetch.sv
// ============================================================================
// Module   : fetch_prefetch
// Purpose  : Instruction prefetch queue with BR/JMP redirect and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_prefetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fetch_prefetch_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   C_DEPTH_OCC = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_fetch_addr;
    logic [ADDR_W-1:0]   r_next_seq;
    logic [ADDR_W-1:0]   r_inflight_addr;
    logic                r_inflight;
    logic [15:0]         r_q_data [DEPTH];
    logic [ADDR_W-1:0]   r_q_addr [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_run;
    logic                w_br_take;
    logic                w_jmp;
    logic                w_redirect;
    logic [ADDR_W-1:0]   w_off_sext;
    logic [ADDR_W-1:0]   w_target;
    logic [CNT_W:0]      w_occ;
    logic                w_issue;
    logic                w_valid;
    logic                w_pop;
    logic                w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    generate
        if (ADDR_W > 9) begin : g_sext_wide
            assign w_off_sext = {{(ADDR_W-9){bus.offset_in[8]}}, bus.offset_in};
        end else begin : g_sext_exact
            assign w_off_sext = bus.offset_in[ADDR_W-1:0];
        end
    endgenerate

    assign w_run      = (r_state == ST_RUN);
    assign w_br_take  = bus.redirect_valid && (bus.opCode_in == 4'b0000)
                        && ((bus.br_nzp & bus.result_nzp) != 3'b000);
    assign w_jmp      = bus.redirect_valid && (bus.opCode_in == 4'b1100);
    assign w_redirect = w_run && (w_br_take || w_jmp);
    assign w_target   = w_jmp ? bus.reg_in : (r_next_seq + w_off_sext);

    // In-flight word counts against capacity so a returning read always has a slot.
    assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue = w_run && !w_redirect && (w_occ < C_DEPTH_OCC);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.inst_ready;
    assign w_push  = r_inflight && !w_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.fetch_start) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_addr    <= RESET_PC;
            r_next_seq      <= RESET_PC;
            r_inflight_addr <= RESET_PC;
            r_inflight      <= 1'b0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
        end else if (w_redirect) begin
            // Redirect outranks a simultaneous pop: next_seq keeps its old value.
            r_fetch_addr <= w_target;
            r_inflight   <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= r_fetch_addr;
                r_fetch_addr    <= r_fetch_addr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr   <= ptr_inc(r_rd_ptr);
                r_next_seq <= r_q_addr[r_rd_ptr] + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= bus.mem_data_in;
            r_q_addr[r_wr_ptr] <= r_inflight_addr;
        end
    end

    assign bus.addr_out   = r_fetch_addr;
    assign bus.mem_rd_out = w_issue;
    assign bus.wea_out    = 1'b0;
    assign bus.inst_valid = w_valid;
    assign bus.inst_out   = w_valid ? r_q_data[r_rd_ptr] : 16'h0000;
    assign bus.pc         = w_valid ? r_q_addr[r_rd_ptr] : r_fetch_addr;

endmodule

`default_nettype wire
